button_cmd_arbiter: RTL and testbench

Collects press events from NUM_BUTTONS debounced, active-low push-button levels. Holds one pending request per button and grants them round-robin. Each grant is presented as a single command (button index) to the serial-bus master over a valid/ready handshake. After each accepted command, a programmable cool-down paces the bus. The block sits between the per-button debouncers and the bus master command port.

---
 rtl/button_cmd_arbiter.sv | 129 ++++++++++++
 tb/tb_button_cmd_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/button_cmd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : button_cmd_arbiter
// Brief  : Turns active-low button presses into round-robin granted commands
//          on a valid/ready port, with a fixed cool-down after each accept.
// Rev    : 1.0  initial release
// ============================================================================
module button_cmd_arbiter #(
    parameter int NUM_BUTTONS     = 4,
    parameter int COOLDOWN_CYCLES = 3,
    localparam int ID_W           = $clog2(NUM_BUTTONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] btn_in,
    input  logic                   cmd_ready,
    input  logic                   clear_overrun,
    output logic                   cmd_valid,
    output logic [ID_W-1:0]        cmd_id,
    output logic                   busy,
    output logic [NUM_BUTTONS-1:0] overrun
);

    localparam int                 c_cnt_w     = (COOLDOWN_CYCLES < 1) ? 1 : $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cool_init = c_cnt_w'(COOLDOWN_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cool_last = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_offer = 2'd1;
    localparam logic [1:0] c_st_cool  = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [NUM_BUTTONS-1:0] r_prev_btn;
    logic [NUM_BUTTONS-1:0] r_pending;
    logic [NUM_BUTTONS-1:0] r_overrun;
    logic [ID_W-1:0]        r_last_grant;
    logic [ID_W-1:0]        r_cmd_id;
    logic [c_cnt_w-1:0]     r_cool;

    logic [NUM_BUTTONS-1:0] w_press;
    logic [NUM_BUTTONS-1:0] w_acc_mask;
    logic                   w_accept;
    logic                   w_any;
    logic                   w_found;
    logic [ID_W-1:0]        w_cand;
    logic [ID_W-1:0]        w_winner;

    // prev_btn resets low so a button held through reset needs a fresh press
    assign w_press  = r_prev_btn & ~btn_in;
    assign w_accept = (r_state == c_st_offer) & cmd_ready;
    assign w_any    = |r_pending;

    always_comb begin
        w_acc_mask = '0;
        if (w_accept) begin
            w_acc_mask[r_cmd_id] = 1'b1;
        end
    end

    // First pending index at or after last_grant+1, wrapping
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int off = 1; off <= NUM_BUTTONS; off++) begin
            w_cand = ID_W'((int'(r_last_grant) + off) % NUM_BUTTONS);
            if (!w_found && r_pending[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_any) w_state_nxt = c_st_offer;
            c_st_offer: if (w_accept) w_state_nxt = (COOLDOWN_CYCLES == 0) ? c_st_idle : c_st_cool;
            c_st_cool:  if (r_cool <= c_cool_last) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        cmd_valid = (r_state == c_st_offer);
        busy      = (r_state != c_st_idle);
    end

    // A press on the button being accepted re-arms it rather than overrunning
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_btn   <= '0;
            r_pending    <= '0;
            r_overrun    <= '0;
            r_last_grant <= ID_W'(NUM_BUTTONS - 1);
            r_cmd_id     <= '0;
            r_cool       <= '0;
        end else begin
            r_prev_btn <= btn_in;
            r_pending  <= (r_pending & ~w_acc_mask) | w_press;
            r_overrun  <= (r_overrun & {NUM_BUTTONS{~clear_overrun}})
                        | (w_press & r_pending & ~w_acc_mask);
            if ((r_state == c_st_idle) && w_any) begin
                r_cmd_id <= w_winner;
            end
            if (w_accept) begin
                r_last_grant <= r_cmd_id;
                r_cool       <= c_cool_init;
            end else if ((r_state == c_st_cool) && (r_cool != '0)) begin
                r_cool <= r_cool - c_cool_last;
            end
        end
    end

    assign cmd_id  = r_cmd_id;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_button_cmd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_button_cmd_arbiter
// Brief  : Scoreboard bench for button_cmd_arbiter (4 buttons, cool-down 3).
// Rev    : 1.0  initial release
// ============================================================================
module tb_button_cmd_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_in;
    logic       cmd_ready;
    logic       clear_overrun;
    logic       cmd_valid;
    logic [1:0] cmd_id;
    logic       busy;
    logic [3:0] overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];
    int acc_cyc[$];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_cmd_arbiter #(
        .NUM_BUTTONS     (4),
        .COOLDOWN_CYCLES (3)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .cmd_ready     (cmd_ready),
        .clear_overrun (clear_overrun),
        .cmd_valid     (cmd_valid),
        .cmd_id        (cmd_id),
        .busy          (busy),
        .overrun       (overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask);
        btn_in = ~mask;
        tick(1);
        btn_in = 4'hF;
    endtask

    // Every handshake seen here is accepted at the following rising edge
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            check_eq("sb_expected_present", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check_eq("sb_cmd_id", cmd_id, exp_q.pop_front());
            acc_cyc.push_back(cyc);
        end
    end

    initial begin
        int seen;
        int nv;
        int nb;
        int bad;
        int base;

        rst = 1'b0; btn_in = 4'b1110; cmd_ready = 1'b0; clear_overrun = 1'b0;
        #1 rst = 1'b1;
        #3;
        check_eq("rst_valid", cmd_valid, 0);
        check_eq("rst_id", cmd_id, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", overrun, 0);
        tick(2);
        rst = 1'b0;

        // Button 0 held through reset must not fire
        seen = 0;
        repeat (20) begin tick(1); if (cmd_valid) seen = 1; end
        check_eq("t1_held_no_valid", seen, 0);
        btn_in = 4'hF; tick(2);
        exp_q.push_back(0);
        press(4'b0001);
        check_eq("t1_valid_after_k", cmd_valid, 0);
        tick(1);
        check_eq("t1_valid_after_k1", cmd_valid, 1);
        check_eq("t1_id", cmd_id, 0);
        cmd_ready = 1'b1;
        tick(1);
        check_eq("t1_valid_dropped", cmd_valid, 0);
        tick(6);

        // Single press with ready high: 1 offer cycle, 4 busy cycles
        exp_q.push_back(2);
        press(4'b0100);
        nv = 0; nb = 0;
        repeat (8) begin tick(1); nv += int'(cmd_valid); nb += int'(busy); end
        check_eq("t2_valid_cycles", nv, 1);
        check_eq("t2_busy_cycles", nb, 4);

        // Accept of id 3 coincides with a fresh btn3 press
        base = acc_cyc.size();
        exp_q.push_back(3); exp_q.push_back(3);
        btn_in = 4'b0111; tick(1);
        btn_in = 4'hF;    tick(1);
        check_eq("t5_valid", cmd_valid, 1);
        check_eq("t5_id", cmd_id, 3);
        btn_in = 4'b0111; tick(1);
        btn_in = 4'hF;
        check_eq("t5_no_overrun", overrun, 0);
        tick(12);
        check_eq("t5_accepts", acc_cyc.size() - base, 2);
        if (acc_cyc.size() >= base + 2) check_eq("t5_gap", acc_cyc[base+1] - acc_cyc[base], 5);

        // All four at once, last grant was 3 so order is 0,1,2,3
        base = acc_cyc.size();
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        press(4'hF);
        tick(25);
        check_eq("t3_accepts", acc_cyc.size() - base, 4);
        for (int i = 1; i < 4; i++) begin
            if (acc_cyc.size() > base + i) check_eq("t3_gap", acc_cyc[base+i] - acc_cyc[base+i-1], 5);
        end
        exp_q.push_back(1); exp_q.push_back(3);
        press(4'b1010);
        tick(12);
        check_eq("t3_accepts_total", acc_cyc.size() - base, 6);

        // Stalled offer, re-press sets overrun only
        cmd_ready = 1'b0;
        exp_q.push_back(1);
        press(4'b0010);
        tick(1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            btn_in = (i == 3) ? 4'b1101 : 4'hF;
            tick(1);
            if (!(cmd_valid && cmd_id == 2'd1)) bad++;
        end
        btn_in = 4'hF;
        check_eq("t4_stable_offer", bad, 0);
        check_eq("t4_overrun", overrun, 4'b0010);
        base = acc_cyc.size();
        cmd_ready = 1'b1;
        tick(10);
        check_eq("t4_single_accept", acc_cyc.size() - base, 1);
        check_eq("t4_idle", busy, 0);
        check_eq("t4_overrun_sticky", overrun, 4'b0010);
        clear_overrun = 1'b1; tick(1); clear_overrun = 1'b0;
        check_eq("t4_overrun_cleared", overrun, 0);

        // Reset mid-offer discards everything pending
        cmd_ready = 1'b0;
        press(4'b1101);
        tick(2);
        check_eq("t6_valid_before_rst", cmd_valid, 1);
        check_eq("t6_id_before_rst", cmd_id, 2);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_valid_async", cmd_valid, 0);
        check_eq("t6_busy_async", busy, 0);
        tick(2);
        rst = 1'b0;
        cmd_ready = 1'b1;
        base = acc_cyc.size();
        seen = 0;
        repeat (20) begin tick(1); if (cmd_valid) seen = 1; end
        check_eq("t6_no_valid_after_rst", seen, 0);
        check_eq("t6_no_accept_after_rst", acc_cyc.size() - base, 0);
        exp_q.push_back(0);
        press(4'b0001);
        tick(6);
        check_eq("t6_new_press_accept", acc_cyc.size() - base, 1);

        check_eq("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
